// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - show-ahead fetch FIFO feeding the IF/ID register
module instr_fetch_queue #(
    parameter int DEPTH       = 4,
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid,
    input  logic [INSTR_WIDTH-1:0]   fetch_instr,
    input  logic [PC_WIDTH-1:0]      fetch_pc,
    output logic                     fetch_ready,
    input  logic                     Stall,
    input  logic                     Flush,
    output logic                     out_valid,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem_q    [DEPTH];

    assign fetch_ready = (count_q != CNT_W'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    assign out_pc      = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign count       = count_q;

    // Flush kills both the push and the pop so the IF/ID capture and queue stay consistent.
    always_comb begin
        push     = fetch_valid && fetch_ready && !Flush;
        pop      = out_valid && !Stall && !Flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= fetch_instr;
            pc_mem_q[wr_ptr_q]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        Stall;
    logic        Flush;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch_queue #(
        .DEPTH(4), .INSTR_WIDTH(32), .PC_WIDTH(32), .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready),
        .Stall(Stall), .Flush(Flush),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_instr = 32'hA000_0000 | pc;
    endtask

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
        Stall = 1'b0; Flush = 1'b0;
        #22 rst = 1'b0;
        step();

        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_instr", out_instr, 32'h13);
        check_eq("rst_pc", out_pc, 0);
        check_eq("rst_ready", fetch_ready, 1);
        check_eq("rst_count", count, 0);

        // streaming: each entry visible the cycle after its push, occupancy stays 1
        for (int i = 0; i < 3; i++) begin
            drive_push(32'(4 * i));
            step();
            check_eq("stream_pc", out_pc, 32'(4 * i));
            check_eq("stream_instr", out_instr, 32'hA000_0000 | 32'(4 * i));
            check_eq("stream_count", count, 1);
        end
        fetch_valid = 1'b0;
        step();
        check_eq("stream_drained", out_valid, 0);

        // stall fill to full, fifth push refused
        Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_push(32'h100 + 32'(4 * i));
            check_eq("fill_ready_pre", fetch_ready, (i < 4) ? 1 : 0);
            step();
            check_eq("fill_count", count, (i < 4) ? i + 1 : 4);
        end
        check_eq("full_ready", fetch_ready, 0);
        fetch_valid = 1'b0;
        Stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_pc", out_pc, 32'h100 + 32'(4 * i));
            step();
            check_eq("drain_ready", fetch_ready, 1);
            check_eq("drain_count", count, 3 - i);
        end
        check_eq("drain_empty_instr", out_instr, 32'h13);

        // wrap-around at occupancy 2
        Stall = 1'b1;
        drive_push(32'h200); step();
        drive_push(32'h204); step();
        Stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq("wrap_pc", out_pc, 32'h200 + 32'(4 * i));
            drive_push(32'h208 + 32'(4 * i));
            step();
            check_eq("wrap_count", count, 2);
        end
        fetch_valid = 1'b0;
        check_eq("wrap_tail0", out_pc, 32'h228);
        step();
        check_eq("wrap_tail1", out_pc, 32'h22C);
        step();
        check_eq("wrap_empty", count, 0);

        // flush with simultaneous push
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_push(32'h300 + 32'(4 * i));
            step();
        end
        check_eq("preflush_count", count, 3);
        Flush = 1'b1;
        fetch_valid = 1'b1; fetch_pc = 32'hDEAD; fetch_instr = 32'hDEAD_BEEF;
        step();
        Flush = 1'b0; fetch_valid = 1'b0;
        check_eq("flush_count", count, 0);
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_instr", out_instr, 32'h13);
        check_eq("flush_pc", out_pc, 0);
        step();
        check_eq("flush_no_ghost", out_valid, 0);
        Stall = 1'b0;

        // async reset between edges with three entries queued
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_push(32'h380 + 32'(4 * i));
            step();
        end
        fetch_valid = 1'b0;
        check_eq("prerst_count", count, 3);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_count", count, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        Stall = 1'b0;
        @(posedge clk); #1;
        drive_push(32'h400);
        step();
        fetch_valid = 1'b0;
        check_eq("resume_valid", out_valid, 1);
        check_eq("resume_pc", out_pc, 32'h400);
        step();
        check_eq("resume_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Show-ahead instruction FIFO between the instruction-memory fetch port and the IF/ID `PipeStage` register. It absorbs fetch responses that arrive while decode is stalled and presents one instruction/PC pair per cycle to the IF/ID register input. It drops all buffered and in-flight-accepted entries on a pipeline flush. When empty it presents a NOP bubble.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `INSTR_WIDTH`, 32, instruction word width.
- `PC_WIDTH`, 32, program-counter width.
- `NOP_INSTR`, 32'h0000_0013, word presented when the queue is empty (`addi x0,x0,0`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `fetch_valid`  in  1  fetch response valid.
- `fetch_instr`  in  INSTR_WIDTH  fetched instruction word.
- `fetch_pc`  in  PC_WIDTH  PC of `fetch_instr`.
- `fetch_ready`  out  1  queue can accept a response this cycle.
- `Stall`  in  1  decode stall; same signal drives the IF/ID `PipeStage`.
- `Flush`  in  1  pipeline flush; same signal drives the IF/ID `PipeStage`.
- `out_valid`  out  1  head entry present.
- `out_instr`  out  INSTR_WIDTH  head instruction, or `NOP_INSTR` when empty.
- `out_pc`  out  PC_WIDTH  head PC, or 0 when empty.
- `count`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries. It holds `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits and wrapping modulo DEPTH, plus a `count` register.
- Push: `fetch_valid && fetch_ready && !Flush` writes the entry at `wr_ptr` and increments `wr_ptr`.
- Pop: `out_valid && !Stall && !Flush` increments `rd_ptr`. The popped entry is the one the IF/ID register captures on that same edge.
- `fetch_ready = (count != DEPTH)`. It depends only on registered state, never on `Stall`. A full queue refuses a push even when a pop occurs in the same cycle.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Flush has priority over every other event. On the edge where `Flush`=1:
  - `count`, `wr_ptr` and `rd_ptr` clear to 0.
  - Any concurrent `fetch_valid` data is discarded.
  - `Stall` is ignored.
- Stall with the queue not full: pushes continue and no pop occurs.
- Outputs are combinational from head state:
  - `out_valid = (count != 0)`.
  - `out_instr = out_valid ? mem[rd_ptr] : NOP_INSTR`.
  - `out_pc = out_valid ? pc_mem[rd_ptr] : 0`.
- An empty queue with no stall lets the IF/ID register capture the NOP bubble. Pushing and popping the same entry in one cycle is not possible; an entry is visible at the head no earlier than the cycle after its push.
- Entry memory contents are not reset. Pointers and count are reset.

## Timing
- Reset (async assert, sync-safe release): `count`=0, pointers=0. Outputs: `out_valid`=0, `out_instr`=`NOP_INSTR`, `out_pc`=0, `fetch_ready`=1.
- Fill latency: response accepted at edge N is presented on `out_*` during cycle N+1.
- Throughput: one push and one pop per cycle sustained at any occupancy below DEPTH.
- Both pointers wrap from DEPTH−1 to 0 without disturbing FIFO order.
- Reset mid-operation: queue state is lost immediately and asynchronously, independent of `clk`.
- Flush edge: queue is empty from the next cycle. `out_*` shows the NOP bubble until the first post-flush push becomes visible (earliest 1 cycle after the flush edge).

## Test plan
- Reset then idle. Hold `rst`=1, then release. Required: `out_valid`=0, `out_instr`=32'h00000013, `out_pc`=0, `fetch_ready`=1, `count`=0.
- Streaming. With `Stall`=0, push PCs 0x0, 0x4, 0x8 on consecutive edges. Required: `out_pc` shows 0x0, 0x4, 0x8 on the three cycles following each push, and `count` never exceeds 1.
- Stall fill and full. Hold `Stall`=1 and push 5 entries with DEPTH=4. Required: `count` reaches 4, `fetch_ready` drops to 0 after the 4th push, and the 5th is refused. Release the stall; required: entries drain in order with `fetch_ready` returning to 1 the cycle after the first pop.
- Wrap-around. Perform 10 push/pop pairs with occupancy held at 2. Required: all 10 PCs emerge in order with no duplication or loss.
- Flush with simultaneous push. With 3 entries queued, assert `Flush`=1 and `fetch_valid`=1 in the same cycle. Required: next cycle `count`=0, `out_valid`=0, `out_instr`=NOP, and the pushed word never appears.
- Async reset mid-stream. Assert `rst` between clock edges while `count`=3. Required: `out_valid` falls to 0 before the next `clk` edge, and normal operation resumes after release.
